rom_bus_arbiter: RTL and testbench
==================================

# rom_bus_arbiter

Two-port arbiter that shares the single Wishbone-style program ROM (32 KB bootloader + application space) between the CPU instruction-fetch port and the data/load port. It sits between the core's ibus/dbus and the ROM. It grants one access at a time with round-robin fairness, issues a single-cycle ROM strobe, and returns a registered ack/data pulse to the owner. Writes to ROM are rejected with an error response, and a missing ROM ack is terminated by a timeout error.

## Interface
Parameters:
- ADDR_WIDTH, 15, ROM byte-address width forwarded to the ROM
- DATA_WIDTH, 32, data width
- TIMEOUT, 15, max cycles in WAIT before error; must be ≥ 1; counter width is $clog2(TIMEOUT+1)

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- i_stb  in  1  instruction request; held until i_ack or i_err
- i_addr  in  32  instruction byte address
- i_data  out  DATA_WIDTH  registered read data
- i_ack  out  1  one-cycle completion pulse
- i_err  out  1  one-cycle error pulse
- d_stb  in  1  data request; held until d_ack or d_err
- d_we  in  1  data write enable; a write is always an error
- d_addr  in  32  data byte address
- d_data  out  DATA_WIDTH  registered read data
- d_ack  out  1  one-cycle completion pulse
- d_err  out  1  one-cycle error pulse
- rom_addr  out  ADDR_WIDTH  ROM byte address
- rom_stb  out  1  ROM strobe, high for exactly one cycle per access
- rom_data  in  DATA_WIDTH  ROM read data
- rom_ack  in  1  ROM ack; nominally one cycle after rom_stb

## Operation
- States: IDLE, ISSUE, WAIT, RESP. The owner register is I or D. last_grant resets to D, so I wins the first tie.
- IDLE: if no request, stay. If exactly one of i_stb or d_stb is high, grant it. If both are high, grant the port ≠ last_grant. Each grant sets owner and last_grant.
  - Granted D with d_we=1: go to RESP with err pending. No ROM access occurs.
  - Otherwise: latch rom_addr ← addr[ADDR_WIDTH-1:0] and go to ISSUE.
- ISSUE: rom_stb=1 for this cycle only; clear the timeout counter; go to WAIT. A rom_ack seen in ISSUE is ignored.
- WAIT: rom_stb=0.
  - On rom_ack: capture owner data ← rom_data; go to RESP with ack pending.
  - Otherwise the counter increments. When the counter reaches TIMEOUT without rom_ack: owner data ← 0; go to RESP with err pending.
- RESP: the owner's ack or err is high for exactly this cycle, and never both. Go to IDLE.
- A rom_ack arriving in IDLE or RESP, e.g. a late ack after timeout, is ignored.
- A requester that drops stb mid-transaction does not abort it. The transaction runs to RESP and the pulse is still issued.
- The non-owner's data output holds its last value. Address bits above ADDR_WIDTH are ignored, because decode is done upstream.
- Reset, including mid-transaction: state=IDLE, owner=I, last_grant=D, counter=0, and all outputs 0 (rom_stb, rom_addr, i/d_ack, i/d_err, i/d_data). A pending ack or err is discarded.

## Timing
- Request sampled in IDLE at cycle 0. rom_stb=1 in cycle 1. rom_ack in cycle 2 (ROM 1-cycle latency). Owner ack and data valid in cycle 3.
- Read latency is 3 cycles from the first stb cycle.
- Back-to-back throughput: one access per 4 cycles. IDLE is revisited in cycle 4, and the next rom_stb comes in cycle 5.
- Write error: grant in cycle 0, d_err=1 in cycle 1, no rom_stb.
- Timeout: with rom_stb in cycle 1 and no ack, err is asserted in cycle 2+TIMEOUT. For TIMEOUT=15 that is cycle 17.
- Simultaneous continuous requests from both ports alternate I, D, I, D, with rom_stb cycles at 1, 5, 9, 13.
- Outputs are registered. There is no combinational path from rom_data or rom_ack to any requester output.

## Test plan
- Single fetch: i_stb=1, i_addr=0x00000000 at cycle 0 after reset -> rom_stb=1 with rom_addr=0x0000 in cycle 1; i_ack=1 with i_data = ROM word 0 in cycle 3 only; d_ack/d_err stay 0.
- Contention: i_stb=d_stb=1 continuously, i_addr=0x00004004, d_addr=0x00000008 -> grant order I, D, I, D; rom_addr sequence 0x4004, 0x0008, 0x4004, 0x0008 with rom_stb at cycles 1, 5, 9, 13.
- Write reject: d_stb=1, d_we=1, d_addr=0x100 -> d_err=1 in cycle 1 for one cycle; rom_stb never asserted; d_data unchanged.
- Timeout: ROM model suppresses ack, TIMEOUT=15 -> i_err=1 at cycle 17 with i_data=0. A later injected rom_ack in IDLE produces no pulse.
- Reset mid-WAIT: assert rst in cycle 2 of a fetch -> next cycle all outputs 0 and state IDLE; the ROM ack in that cycle produces no i_ack. A fresh request afterwards completes normally (3-cycle latency).
- Dropped stb: i_stb deasserted in cycle 2 -> i_ack still pulses in cycle 3. A concurrent d_stb is served next, with rom_stb in cycle 5.

Source files
------------

// File: rtl/rom_bus_arbiter_if.sv
// Bus bundle between the core's ibus/dbus, the ROM arbiter and the program ROM.
// slave: arbiter view; master: core + ROM view.
interface rom_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
);
  logic                  i_stb;
  logic [31:0]           i_addr;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_ack;
  logic                  i_err;

  logic                  d_stb;
  logic                  d_we;
  logic [31:0]           d_addr;
  logic [DATA_WIDTH-1:0] d_data;
  logic                  d_ack;
  logic                  d_err;

  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_stb;
  logic [DATA_WIDTH-1:0] rom_data;
  logic                  rom_ack;

  modport slave (
    input  i_stb, i_addr,
    output i_data, i_ack, i_err,
    input  d_stb, d_we, d_addr,
    output d_data, d_ack, d_err,
    output rom_addr, rom_stb,
    input  rom_data, rom_ack
  );

  modport master (
    output i_stb, i_addr,
    input  i_data, i_ack, i_err,
    output d_stb, d_we, d_addr,
    input  d_data, d_ack, d_err,
    input  rom_addr, rom_stb,
    output rom_data, rom_ack
  );
endinterface

// File: rtl/rom_bus_arbiter.sv
// Round-robin arbiter sharing the program ROM between instruction fetch and data load ports.
// Writes are rejected with an error; a missing ROM ack ends in a timeout error.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transaction; arbitrate between i_stb and d_stb
// ST_ISSUE | rom_stb high for this single cycle; timeout counter cleared
// ST_WAIT  | waiting for rom_ack, counting towards TIMEOUT
// ST_RESP  | owner's ack or err pulse is high for this cycle
module rom_bus_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             rst,
  rom_bus_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t                state;
  logic                  owner_d;
  logic                  last_grant_d;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] rom_addr_q;
  logic                  rom_stb_q;
  logic [DATA_WIDTH-1:0] i_data_q;
  logic [DATA_WIDTH-1:0] d_data_q;
  logic                  i_ack_q;
  logic                  i_err_q;
  logic                  d_ack_q;
  logic                  d_err_q;
  logic                  grant_d;

  // On a tie the port that did not win last time gets the grant.
  assign grant_d = bus.d_stb & (~bus.i_stb | ~last_grant_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      owner_d      <= 1'b0;
      last_grant_d <= 1'b1;
      cnt          <= '0;
      rom_addr_q   <= '0;
      rom_stb_q    <= 1'b0;
      i_data_q     <= '0;
      d_data_q     <= '0;
      i_ack_q      <= 1'b0;
      i_err_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
    end else begin
      rom_stb_q <= 1'b0;
      i_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.i_stb || bus.d_stb) begin
            owner_d      <= grant_d;
            last_grant_d <= grant_d;
            if (grant_d && bus.d_we) begin
              d_err_q <= 1'b1;
              state   <= ST_RESP;
            end else begin
              rom_addr_q <= grant_d ? bus.d_addr[ADDR_WIDTH-1:0] : bus.i_addr[ADDR_WIDTH-1:0];
              rom_stb_q  <= 1'b1;
              state      <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.rom_ack) begin
            if (owner_d) begin
              d_data_q <= bus.rom_data;
              d_ack_q  <= 1'b1;
            end else begin
              i_data_q <= bus.rom_data;
              i_ack_q  <= 1'b1;
            end
            state <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_ONE;
            if (cnt == CNT_LAST) begin
              if (owner_d) begin
                d_data_q <= '0;
                d_err_q  <= 1'b1;
              end else begin
                i_data_q <= '0;
                i_err_q  <= 1'b1;
              end
              state <= ST_RESP;
            end
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.rom_stb  = rom_stb_q;
  assign bus.i_data   = i_data_q;
  assign bus.i_ack    = i_ack_q;
  assign bus.i_err    = i_err_q;
  assign bus.d_data   = d_data_q;
  assign bus.d_ack    = d_ack_q;
  assign bus.d_err    = d_err_q;

  // Upper address bits are decoded upstream.
  if (ADDR_WIDTH < 32) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^{bus.i_addr[31:ADDR_WIDTH], bus.d_addr[31:ADDR_WIDTH]};
  end
endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Self-checking bench for rom_bus_arbiter: directed scenarios plus randomized rounds
// compared against a transaction-level timing model of the arbiter.
module tb_rom_bus_arbiter;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int TO = 15;
  localparam int BUDGET = 200;

  typedef struct {
    int          cyc;
    bit          err;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rom_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rom_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state carried across rounds.
  bit          m_last_d;
  logic [31:0] m_i_data;
  logic [31:0] m_d_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, ".pulses"}, {59'd0, bus.rom_stb, bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}, 64'd0);
    check({tag, ".rom_addr"}, 64'(bus.rom_addr), 64'd0);
    check({tag, ".i_data"}, 64'(bus.i_data), 64'd0);
    check({tag, ".d_data"}, 64'(bus.d_data), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.i_stb = 1'b0; bus.d_stb = 1'b0; bus.d_we = 1'b0; bus.rom_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero(tag);
    @(posedge clk); #1;
    rst = 1'b0;
    m_last_d = 1'b1;
    m_i_data = '0;
    m_d_data = '0;
  endtask

  // One round: port I makes n_i reads at ai, port D makes n_d accesses at ad (all
  // writes when we=1). Each port holds stb until its last pulse. Cycle 0 is the
  // first cycle both requests are visible in IDLE.
  task automatic run_round(input string tag, input int n_i, input int n_d, input bit we,
                           input logic [31:0] ai, input logic [31:0] ad,
                           input bit ack_en, input int drop_i_at);
    ev_t exp_i[$], exp_d[$], obs_i[$], obs_d[$];
    int exp_sc[$], obs_sc[$];
    logic [AW-1:0] exp_sa[$], obs_sa[$];
    int t, ri, rd, c;
    bit gd, dropped, pend_ack;
    logic [AW-1:0] a, pend_a;
    logic [31:0] dv;
    int rt;

    // Reference timeline: grant at t, strobe t+1, ack t+3 / timeout err t+2+TO,
    // write err t+1; next arbitration one cycle after the response.
    t = 0; ri = n_i; rd = n_d;
    while (ri > 0 || rd > 0) begin
      gd = (rd > 0) && (ri == 0 || !m_last_d);
      m_last_d = gd;
      if (gd && we) begin
        exp_d.push_back('{t + 1, 1'b1, m_d_data});
        rd--;
        t += 2;
      end else begin
        a = gd ? ad[AW-1:0] : ai[AW-1:0];
        exp_sc.push_back(t + 1);
        exp_sa.push_back(a);
        if (ack_en) begin dv = rom_word(a); rt = t + 3; t += 4; end
        else        begin dv = '0;          rt = t + 2 + TO; t += 3 + TO; end
        if (gd) begin m_d_data = dv; exp_d.push_back('{rt, !ack_en, dv}); rd--; end
        else    begin m_i_data = dv; exp_i.push_back('{rt, !ack_en, dv}); ri--; end
      end
    end

    @(posedge clk); #1;
    c = 0; ri = n_i; rd = n_d; dropped = 1'b0;
    bus.i_addr = ai; bus.d_addr = ad; bus.d_we = we;
    bus.i_stb = (ri > 0); bus.d_stb = (rd > 0);
    bus.rom_ack = 1'b0; bus.rom_data = $urandom();
    while ((ri > 0 || rd > 0) && c < BUDGET) begin
      @(negedge clk);
      if (bus.rom_stb) begin obs_sc.push_back(c); obs_sa.push_back(bus.rom_addr); end
      pend_ack = bus.rom_stb && ack_en;
      pend_a   = bus.rom_addr;
      if ((bus.i_ack && bus.i_err) || (bus.d_ack && bus.d_err))
        check($sformatf("%s.ack_and_err_c%0d", tag, c), 1, 0);
      if (bus.i_ack || bus.i_err) begin obs_i.push_back('{c, bus.i_err, bus.i_data}); ri--; end
      if (bus.d_ack || bus.d_err) begin obs_d.push_back('{c, bus.d_err, bus.d_data}); rd--; end
      @(posedge clk); #1;
      c++;
      bus.rom_ack  = pend_ack;
      bus.rom_data = pend_ack ? rom_word(pend_a) : $urandom();
      if (c == drop_i_at) dropped = 1'b1;
      bus.i_stb = (ri > 0) && !dropped;
      bus.d_stb = (rd > 0);
    end
    bus.i_stb = 1'b0; bus.d_stb = 1'b0; bus.rom_ack = 1'b0;

    check({tag, ".i_count"}, 64'(obs_i.size()), 64'(exp_i.size()));
    check({tag, ".d_count"}, 64'(obs_d.size()), 64'(exp_d.size()));
    check({tag, ".stb_count"}, 64'(obs_sc.size()), 64'(exp_sc.size()));
    for (int k = 0; k < exp_i.size() && k < obs_i.size(); k++) begin
      check($sformatf("%s.i%0d_cycle", tag, k), 64'(obs_i[k].cyc), 64'(exp_i[k].cyc));
      check($sformatf("%s.i%0d_err", tag, k), 64'(obs_i[k].err), 64'(exp_i[k].err));
      check($sformatf("%s.i%0d_data", tag, k), 64'(obs_i[k].data), 64'(exp_i[k].data));
    end
    for (int k = 0; k < exp_d.size() && k < obs_d.size(); k++) begin
      check($sformatf("%s.d%0d_cycle", tag, k), 64'(obs_d[k].cyc), 64'(exp_d[k].cyc));
      check($sformatf("%s.d%0d_err", tag, k), 64'(obs_d[k].err), 64'(exp_d[k].err));
      check($sformatf("%s.d%0d_data", tag, k), 64'(obs_d[k].data), 64'(exp_d[k].data));
    end
    for (int k = 0; k < exp_sc.size() && k < obs_sc.size(); k++) begin
      check($sformatf("%s.stb%0d_cycle", tag, k), 64'(obs_sc[k]), 64'(exp_sc[k]));
      check($sformatf("%s.stb%0d_addr", tag, k), 64'(obs_sa[k]), 64'(exp_sa[k]));
    end
    check({tag, ".i_data_hold"}, 64'(bus.i_data), 64'(m_i_data));
    check({tag, ".d_data_hold"}, 64'(bus.d_data), 64'(m_d_data));
  endtask

  initial begin
    int n_i, n_d;
    bit we, ack_en;

    rst = 1'b1;
    bus.i_stb = 1'b0; bus.i_addr = '0;
    bus.d_stb = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0;
    bus.rom_ack = 1'b0; bus.rom_data = '0;

    do_reset("reset0");
    run_round("fetch", 1, 0, 1'b0, 32'h0000_0000, 32'h0, 1'b1, -1);

    do_reset("reset1");
    run_round("contention", 2, 2, 1'b0, 32'h0000_4004, 32'h0000_0008, 1'b1, -1);

    run_round("write_reject", 0, 1, 1'b1, 32'h0, 32'h0000_0100, 1'b1, -1);

    run_round("timeout", 1, 0, 1'b0, 32'h0000_1234, 32'h0, 1'b0, -1);
    @(posedge clk); #1;
    bus.rom_ack = 1'b1; bus.rom_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.rom_ack = 1'b0;
    @(negedge clk);
    check("late_ack.no_pulse", {60'd0, bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}, 64'd0);
    check("late_ack.i_data", 64'(bus.i_data), 64'(m_i_data));

    // Reset during WAIT while the ROM is acking.
    @(posedge clk); #1;
    bus.i_stb = 1'b1; bus.i_addr = 32'h0000_0020;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.rom_ack = 1'b1; bus.rom_data = rom_word(15'h0020);
    rst = 1'b1;
    @(posedge clk); #1;
    bus.rom_ack = 1'b0; rst = 1'b0; bus.i_stb = 1'b0;
    @(negedge clk);
    check_outputs_zero("rst_wait");
    m_last_d = 1'b1; m_i_data = '0; m_d_data = '0;
    run_round("after_rst", 1, 0, 1'b0, 32'h0000_0044, 32'h0, 1'b1, -1);

    do_reset("reset2");
    run_round("drop_stb", 1, 1, 1'b0, 32'h0000_0010, 32'h0000_0200, 1'b1, 2);

    for (int r = 0; r < 40; r++) begin
      n_i = $urandom_range(0, 2);
      n_d = $urandom_range(0, 2);
      if (n_i == 0 && n_d == 0) n_i = 1;
      we     = ($urandom_range(0, 3) == 0);
      ack_en = ($urandom_range(0, 7) != 0);
      run_round($sformatf("rnd%0d", r), n_i, n_d, we, $urandom(), $urandom(), ack_en, -1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
